// File: rtl/seg_scan595_hex.sv
// Multiplexed hex 7-segment scanner feeding two cascaded 74HC595s (segment byte first, then select byte).
// Latency: 1 + 33*CLK_DIV + HOLD_CYC sys_clk cycles per digit; frame = NUM_DIGITS digits.
// Backpressure: none; free-running scan, inputs snapshotted at the start of each frame.
//
// Ports: sys_clk/sys_rst (async, active-high); digits_i/dp_i/blank_i per-digit data; bright_i dimming level;
//        sclk/dat/str/oe_n drive the 595 chain; cur_digit = digit being shifted/held; frame_done = wrap strobe.
// Optional feature: define SEG_DIM_EN to enable PWM dimming through oe_n during the hold window.
module seg_scan595_hex #(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_DIV        = 4,
    parameter int HOLD_CYC       = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic [2:0]              bright_i,
    output logic                    sclk,
    output logic                    dat,
    output logic                    str,
    output logic                    oe_n,
    output logic [2:0]              cur_digit,
    output logic                    frame_done
);

    typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_LATCH, S_HOLD} state_t;

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [2:0]  LAST_DIG  = 3'(NUM_DIGITS - 1);

    state_t                  state;
    logic [15:0]             cnt;
    logic [3:0]              bit_cnt;
    logic [15:0]             shreg;
    logic [4*NUM_DIGITS-1:0] snap_dig;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blank;

    // Word build: digit 0 reads the live inputs because the snapshot is taken in that same LOAD cycle.
    logic [31:0] dig_src;
    logic [7:0]  dp_src;
    logic [7:0]  blank_src;
    logic [3:0]  nib;
    logic [7:0]  seg_hex;
    logic [7:0]  seg;
    logic [7:0]  sel;
    logic [15:0] word;

    always_comb begin
        dig_src   = (cur_digit == 3'd0) ? 32'(digits_i) : 32'(snap_dig);
        dp_src    = (cur_digit == 3'd0) ? 8'(dp_i)      : 8'(snap_dp);
        blank_src = (cur_digit == 3'd0) ? 8'(blank_i)   : 8'(snap_blank);
        nib       = dig_src[{cur_digit, 2'b00} +: 4];
        case (nib)
            4'h0: seg_hex = 8'hC0;
            4'h1: seg_hex = 8'hF9;
            4'h2: seg_hex = 8'hA4;
            4'h3: seg_hex = 8'hB0;
            4'h4: seg_hex = 8'h99;
            4'h5: seg_hex = 8'h92;
            4'h6: seg_hex = 8'h82;
            4'h7: seg_hex = 8'hF8;
            4'h8: seg_hex = 8'h80;
            4'h9: seg_hex = 8'h90;
            4'hA: seg_hex = 8'h88;
            4'hB: seg_hex = 8'h83;
            4'hC: seg_hex = 8'hC6;
            4'hD: seg_hex = 8'hA1;
            4'hE: seg_hex = 8'h86;
            default: seg_hex = 8'h8E;
        endcase
        seg = seg_hex;
        if (dp_src[cur_digit])    seg[7] = 1'b0;
        if (blank_src[cur_digit]) seg    = 8'hFF;
        if (SEG_ACTIVE_LOW == 0)  seg    = ~seg;
        sel = 8'b1 << cur_digit;
        if (SEL_ACTIVE_LOW != 0)  sel    = ~sel;
        word = {seg, sel};
    end

`ifdef SEG_DIM_EN
    logic [15:0] on_len;
    logic [15:0] on_calc;
    assign on_calc = ((16'(bright_i) + 16'd1) * 16'(HOLD_CYC)) >> 3;
`else
    assign oe_n = 1'b0;
    logic unused_bright;
    assign unused_bright = ^bright_i;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= S_LOAD;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            snap_dig   <= '0;
            snap_dp    <= '0;
            snap_blank <= '0;
            sclk       <= 1'b0;
            dat        <= 1'b0;
            str        <= 1'b0;
            cur_digit  <= '0;
            frame_done <= 1'b0;
`ifdef SEG_DIM_EN
            oe_n       <= 1'b0;
            on_len     <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (cur_digit == 3'd0) begin
                        snap_dig   <= digits_i;
                        snap_dp    <= dp_i;
                        snap_blank <= blank_i;
                    end
                    shreg   <= word;
                    dat     <= word[15];
                    sclk    <= 1'b0;
                    cnt     <= '0;
                    bit_cnt <= '0;
                    state   <= S_SHIFT;
`ifdef SEG_DIM_EN
                    oe_n    <= 1'b1;
`endif
                end
                S_SHIFT: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == 4'd15) begin
                                dat   <= 1'b0;
                                str   <= 1'b1;
                                state <= S_LATCH;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                shreg   <= shreg << 1;
                                dat     <= shreg[14];
                            end
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_LATCH: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        str <= 1'b0;
                        if (HOLD_CYC == 0) begin
                            cur_digit  <= (cur_digit == LAST_DIG) ? 3'd0 : cur_digit + 3'd1;
                            frame_done <= (cur_digit == LAST_DIG);
                            state      <= S_LOAD;
                        end else begin
                            state <= S_HOLD;
`ifdef SEG_DIM_EN
                            // bright_i is captured here so a change mid-hold cannot glitch the duty.
                            on_len <= on_calc;
                            oe_n   <= (on_calc == 16'd0);
`endif
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    if (cnt == HOLD_LAST) begin
                        cnt        <= '0;
                        cur_digit  <= (cur_digit == LAST_DIG) ? 3'd0 : cur_digit + 3'd1;
                        frame_done <= (cur_digit == LAST_DIG);
                        state      <= S_LOAD;
`ifdef SEG_DIM_EN
                        oe_n       <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 16'd1;
`ifdef SEG_DIM_EN
                        oe_n <= ((cnt + 16'd1) >= on_len);
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan595_hex.sv
module tb_seg_scan595_hex;
    localparam int N     = 8;
    localparam int DIV   = 2;
    localparam int HOLD  = 16;
    localparam int CYC   = 1 + 33 * DIV + HOLD;   // 83 cycles per digit
    localparam int FRAME = N * CYC;               // 664 cycles per frame
    localparam int SHL   = 32 * DIV;              // shift window length

    logic           sys_clk = 1'b0;
    logic           sys_rst = 1'b1;
    logic [4*N-1:0] digits_i = 32'h76543210;
    logic [N-1:0]   dp_i = 8'h08;
    logic [N-1:0]   blank_i = 8'h04;
    logic [2:0]     bright_i = 3'd3;
    logic           sclk, dat, str, oe_n, frame_done;
    logic [2:0]     cur_digit;

    seg_scan595_hex #(.NUM_DIGITS(N), .CLK_DIV(DIV), .HOLD_CYC(HOLD),
                      .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(0)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .digits_i(digits_i), .dp_i(dp_i),
        .blank_i(blank_i), .bright_i(bright_i), .sclk(sclk), .dat(dat), .str(str),
        .oe_n(oe_n), .cur_digit(cur_digit), .frame_done(frame_done));

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: time-indexed view of the scan plus a per-frame snapshot of the inputs.
    logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int             edge_idx = -1;
    logic [4*N-1:0] m_dig;
    logic [N-1:0]   m_dp, m_blank;

    always @(posedge sys_clk) begin
        if (sys_rst) edge_idx = -1;
        else begin
            edge_idx++;
            if (edge_idx % FRAME == 0) begin
                m_dig = digits_i; m_dp = dp_i; m_blank = blank_i;
            end
        end
    end

    function automatic logic [15:0] exp_word(input int k);
        logic [7:0] s;
        logic [3:0] nb;
        nb = m_dig[4*k +: 4];
        s  = hex_tbl[nb];
        if (m_dp[k])    s = s & 8'h7F;
        if (m_blank[k]) s = 8'hFF;
        return {s, 8'(1 << k)};
    endfunction

    logic [15:0] cap;
    logic        prev_sclk, prev_str;
    logic [15:0] words[$];
    int          frames_seen = 0;

    always @(negedge sys_clk) begin
        if (sys_rst || edge_idx < 0) begin
            prev_sclk = 1'b0; prev_str = 1'b0; cap = '0;
        end else begin
            int r, k;
            logic [15:0] w;
            r = edge_idx % CYC;
            k = (edge_idx / CYC) % N;
            w = exp_word(k);
            chk("cur_digit", 32'(cur_digit), (r == CYC - 1) ? 32'((k + 1) % N) : 32'(k));
            chk("frame_done", 32'(frame_done), 32'((edge_idx + 1) % FRAME == 0));
            chk("str", 32'(str), 32'(r >= SHL && r < SHL + DIV));
            if (r < SHL) begin
                chk("sclk", 32'(sclk), 32'((r % (2 * DIV)) >= DIV));
                chk("dat", 32'(dat), 32'(w[15 - r / (2 * DIV)]));
            end else begin
                chk("sclk_idle", 32'(sclk), 32'd0);
                if (r < SHL + DIV) chk("dat_latch", 32'(dat), 32'd0);
            end
`ifdef SEG_DIM_EN
            if (r >= SHL + DIV && r < SHL + DIV + HOLD)
                chk("oe_n_hold", 32'(oe_n),
                    32'((r - SHL - DIV) >= (((int'(bright_i) + 1) * HOLD) >> 3)));
            else
                chk("oe_n_busy", 32'(oe_n), 32'd1);
`else
            chk("oe_n", 32'(oe_n), 32'd0);
`endif
            if (sclk && !prev_sclk) cap = {cap[14:0], dat};
            if (str && !prev_str) begin
                chk("word", 32'(cap), 32'(w));
                words.push_back(cap);
            end
            if (frame_done) frames_seen++;
            prev_sclk = sclk; prev_str = str;
        end
    end

    task automatic wait_edge(input int target);
        int n = 0;
        while (edge_idx != target && n < 3 * FRAME) begin
            @(posedge sys_clk);
            n++;
        end
        if (edge_idx != target) chk("wait_timeout", 32'(edge_idx), 32'(target));
    endtask

    initial begin
        int widx;
        #23;
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_dat", 32'(dat), 32'd0);
        chk("rst_str", 32'(str), 32'd0);
        chk("rst_oe_n", 32'(oe_n), 32'd0);
        chk("rst_cur", 32'(cur_digit), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        // Mid-frame change: only visible from the next frame on.
        wait_edge(2 * CYC + 10);
        @(negedge sys_clk);
        digits_i = 32'hFFFFFFFF;
        wait_edge(2 * FRAME - 5);
        chk("f0_w0", 32'(words[0]), 32'h0000C001);
        chk("f0_w1", 32'(words[1]), 32'h0000F902);
        chk("f0_w2_blank", 32'(words[2]), 32'h0000FF04);
        chk("f0_w3_dp", 32'(words[3]), 32'h00003008);
        chk("f0_w4", 32'(words[4]), 32'h00009910);
        chk("f0_w7", 32'(words[7]), 32'h0000F880);
        chk("f1_w5", 32'(words[13]), 32'h00008E20);
        chk("f1_w3", 32'(words[11]), 32'h00000E08);
        // Randomized inputs changing at arbitrary points over several frames.
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(400, 20)) @(negedge sys_clk);
            digits_i = $urandom;
            dp_i     = 8'($urandom);
            blank_i  = 8'($urandom) & 8'($urandom);
`ifndef SEG_DIM_EN
            bright_i = 3'($urandom);
`endif
        end
        chk("frames_seen", 32'(frames_seen), 32'(edge_idx / FRAME));
        // Asynchronous reset in the middle of digit 5's shift.
        wait_edge(((edge_idx / FRAME) + 1) * FRAME + 5 * CYC + 7 * 2 * DIV + 1);
        #1 sys_rst = 1'b1;
        #1;
        chk("arst_sclk", 32'(sclk), 32'd0);
        chk("arst_dat", 32'(dat), 32'd0);
        chk("arst_str", 32'(str), 32'd0);
        chk("arst_cur", 32'(cur_digit), 32'd0);
        chk("arst_fd", 32'(frame_done), 32'd0);
        digits_i = 32'h76543210; dp_i = '0; blank_i = '0;
        repeat (3) @(negedge sys_clk);
        widx = words.size();
        sys_rst = 1'b0;
        wait_edge(FRAME + 2);
        chk("post_rst_w0", 32'(words[widx]), 32'h0000C001);
        chk("post_rst_w2", 32'(words[widx + 2]), 32'h0000A404);
        chk("post_rst_w7", 32'(words[widx + 7]), 32'h0000F880);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=finish", edge_idx);
        $fatal(1, "timeout");
    end
endmodule
